// File: rtl/alu_issue_arb.sv
// Round-robin issue arbiter sharing one integer ALU between two issue slots.
// An EX operand register drives the ALU; a WB register holds the result under backpressure.
module alu_issue_arb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 14,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [XLEN-1:0]  req0_src1,
  input  logic [XLEN-1:0]  req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [XLEN-1:0]  req1_src1,
  input  logic [XLEN-1:0]  req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [OP_W-1:0]  alu_op,
  output logic [XLEN-1:0]  alu_src1,
  output logic [XLEN-1:0]  alu_src2,
  input  logic [XLEN-1:0]  alu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_result,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_slot
);

  logic             ex_valid_q;
  logic [OP_W-1:0]  ex_op_q;
  logic [XLEN-1:0]  ex_src1_q;
  logic [XLEN-1:0]  ex_src2_q;
  logic [TAG_W-1:0] ex_tag_q;
  logic             ex_slot_q;

  logic             wb_valid_q;
  logic [XLEN-1:0]  wb_result_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic             wb_slot_q;

  logic             rr_ptr_q;

  logic wb_adv, ex_adv, arb_en;
  logic grant0, grant1, grant_any;

  // Grant is also gated by rst_n so ready stays low while reset is held.
  always_comb begin
    wb_adv    = !wb_valid_q || wb_ready;
    ex_adv    = !ex_valid_q || wb_adv;
    arb_en    = rst_n && ex_adv && !flush;
    grant0    = arb_en && req0_valid && (!req1_valid || !rr_ptr_q);
    grant1    = arb_en && req1_valid && (!req0_valid || rr_ptr_q);
    grant_any = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_src1_q   <= '0;
      ex_src2_q   <= '0;
      ex_tag_q    <= '0;
      ex_slot_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_tag_q    <= '0;
      wb_slot_q   <= 1'b0;
      rr_ptr_q    <= 1'b0;
    end else begin
      if (grant_any) begin
        ex_valid_q <= 1'b1;
        ex_op_q    <= grant1 ? req1_op   : req0_op;
        ex_src1_q  <= grant1 ? req1_src1 : req0_src1;
        ex_src2_q  <= grant1 ? req1_src2 : req0_src2;
        ex_tag_q   <= grant1 ? req1_tag  : req0_tag;
        ex_slot_q  <= grant1;
        rr_ptr_q   <= !grant1;
      end else if (flush || ex_adv) begin
        ex_valid_q <= 1'b0;
      end

      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (ex_valid_q && wb_adv) begin
        wb_valid_q  <= 1'b1;
        wb_result_q <= alu_result;
        wb_tag_q    <= ex_tag_q;
        wb_slot_q   <= ex_slot_q;
      end else if (wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign alu_op    = ex_valid_q ? ex_op_q : '0;
  assign alu_src1  = ex_src1_q;
  assign alu_src2  = ex_src2_q;
  assign wb_valid  = wb_valid_q;
  assign wb_result = wb_result_q;
  assign wb_tag    = wb_tag_q;
  assign wb_slot   = wb_slot_q;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed bench for alu_issue_arb: reset, single op, round-robin, backpressure, flush,
// mid-stream reset and single-requester fairness. A small ALU model feeds alu_result.
module tb_alu_issue_arb;

  logic        clk, rst_n, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [13:0] req0_op, req1_op, alu_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [4:0]  req0_tag, req1_tag, wb_tag;
  logic [31:0] alu_src1, alu_src2, alu_result, wb_result;
  logic        wb_valid, wb_ready, wb_slot;

  int vectors = 0;
  int errors  = 0;

  alu_issue_arb dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_tag(wb_tag),
    .wb_slot(wb_slot)
  );

  // Bench ALU: bit0 selects add, anything else xor.
  assign alu_result = alu_op[0] ? (alu_src1 + alu_src2) : (alu_src1 ^ alu_src2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge; checks happen 2 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0; req1_tag = '0;
    wb_ready = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; wb_ready = 1'b0; flush = 1'b1;
    tick();
    #1;
    chk("reset req0_ready", 32'(req0_ready), 32'd0);
    chk("reset req1_ready", 32'(req1_ready), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_result", wb_result, 32'd0);
    chk("reset wb_tag", 32'(wb_tag), 32'd0);
    chk("reset wb_slot", 32'(wb_slot), 32'd0);
    chk("reset alu_op", 32'(alu_op), 32'd0);
    chk("reset alu_src1", alu_src1, 32'd0);
    chk("reset alu_src2", alu_src2, 32'd0);
    tick();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    apply_reset();
    req0_valid = 1'b1; req0_op = 14'h0001; req0_src1 = 32'd5; req0_src2 = 32'd7;
    req0_tag = 5'd3;
    #1;
    chk("single req0_ready", 32'(req0_ready), 32'd1);
    chk("single req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("single alu_op", 32'(alu_op), 32'h1);
    chk("single alu_src1", alu_src1, 32'd5);
    chk("single wb_valid early", 32'(wb_valid), 32'd0);
    tick();
    #1;
    chk("single wb_valid", 32'(wb_valid), 32'd1);
    chk("single wb_result", wb_result, 32'd12);
    chk("single wb_tag", 32'(wb_tag), 32'd3);
    chk("single wb_slot", 32'(wb_slot), 32'd0);
    chk("single alu_op idle", 32'(alu_op), 32'd0);
    tick();
    #1;
    chk("single wb_valid drop", 32'(wb_valid), 32'd0);
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    int k, exp_tag;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      req0_valid = (n0 < 4); req0_op = 14'h0001; req0_tag = 5'(n0);
      req0_src1 = 32'(n0); req0_src2 = 32'd100;
      req1_valid = (n1 < 4); req1_op = 14'h0001; req1_tag = 5'(16 + n1);
      req1_src1 = 32'(16 + n1); req1_src2 = 32'd100;
      #1;
      if (c < 8) begin
        chk("rr req0_ready", 32'(req0_ready), 32'(c % 2 == 0));
        chk("rr req1_ready", 32'(req1_ready), 32'(c % 2 == 1));
      end
      if (c >= 2) begin
        k = c - 2;
        exp_tag = (k % 2 == 1) ? 16 + k / 2 : k / 2;
        chk("rr wb_valid", 32'(wb_valid), 32'd1);
        chk("rr wb_slot", 32'(wb_slot), 32'(k % 2));
        chk("rr wb_tag", 32'(wb_tag), 32'(exp_tag));
        chk("rr wb_result", wb_result, 32'(exp_tag + 100));
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n1 = 0;
    int exp_wb [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
    bit exp_rdy [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      wb_ready = !(c >= 2 && c <= 4);
      req1_valid = (n1 < 4); req1_op = 14'h0002; req1_tag = 5'(8 + n1);
      req1_src1 = 32'(200 + n1); req1_src2 = 32'(n1);
      #1;
      chk("bp req1_ready", 32'(req1_ready), 32'(exp_rdy[c]));
      chk("bp req0_ready", 32'(req0_ready), 32'd0);
      chk("bp wb_valid", 32'(wb_valid), 32'(exp_wb[c] >= 0));
      if (exp_wb[c] >= 0) begin
        chk("bp wb_tag", 32'(wb_tag), 32'(8 + exp_wb[c]));
        chk("bp wb_result", wb_result, 32'(200 + exp_wb[c]) ^ 32'(exp_wb[c]));
        chk("bp wb_slot", 32'(wb_slot), 32'd1);
      end
      if (req1_ready) n1++;
      tick();
    end
    wb_ready = 1'b1;
  endtask

  task automatic test_flush();
    apply_reset();
    req0_valid = 1'b1; req0_op = 14'h0001; req0_src1 = 32'd1; req0_src2 = 32'd1;
    req0_tag = 5'd1;
    tick();
    req0_tag = 5'd2;
    tick();
    flush = 1'b1; req0_tag = 5'd4; req0_src1 = 32'd40; req0_src2 = 32'd2;
    #1;
    chk("flush req0_ready", 32'(req0_ready), 32'd0);
    chk("flush wb_valid before", 32'(wb_valid), 32'd1);
    chk("flush wb_tag before", 32'(wb_tag), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush wb_valid after", 32'(wb_valid), 32'd0);
    chk("flush req0_ready after", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("flush wb_valid gap", 32'(wb_valid), 32'd0);
    tick();
    #1;
    chk("flush next wb_valid", 32'(wb_valid), 32'd1);
    chk("flush next wb_tag", 32'(wb_tag), 32'd4);
    chk("flush next wb_result", wb_result, 32'd42);
    tick();
    #1;
    chk("flush tail wb_valid", 32'(wb_valid), 32'd0);
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    req0_valid = 1'b1; req0_op = 14'h0001; req0_src1 = 32'd7; req0_src2 = 32'd0;
    req0_tag = 5'd7;
    tick();
    req0_tag = 5'd9;
    tick();
    rst_n = 1'b0;
    req0_tag = 5'd12; req0_src1 = 32'd12;
    req1_valid = 1'b1; req1_op = 14'h0001; req1_tag = 5'd13; req1_src1 = 32'd13;
    req1_src2 = 32'd0;
    #1;
    chk("rstmid req0_ready", 32'(req0_ready), 32'd0);
    chk("rstmid req1_ready", 32'(req1_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstmid wb_valid", 32'(wb_valid), 32'd0);
    chk("rstmid alu_op", 32'(alu_op), 32'd0);
    chk("rstmid req0 wins", 32'(req0_ready), 32'd1);
    chk("rstmid req1 loses", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("rstmid req1 next", 32'(req1_ready), 32'd1);
    chk("rstmid no stale wb", 32'(wb_valid), 32'd0);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("rstmid wb_valid", 32'(wb_valid), 32'd1);
    chk("rstmid wb_tag", 32'(wb_tag), 32'd12);
    chk("rstmid wb_slot", 32'(wb_slot), 32'd0);
    tick();
    #1;
    chk("rstmid slot1 wb_tag", 32'(wb_tag), 32'd13);
    chk("rstmid slot1 wb_slot", 32'(wb_slot), 32'd1);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1'b1; req1_op = 14'h0001; req1_tag = 5'(20 + i);
      req1_src1 = 32'(i); req1_src2 = 32'd0;
      #1;
      chk("fair solo req1_ready", 32'(req1_ready), 32'd1);
      tick();
    end
    req0_valid = 1'b1; req0_op = 14'h0001; req0_tag = 5'd30;
    #1;
    chk("fair both req0_ready", 32'(req0_ready), 32'd1);
    chk("fair both req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("fair after req1_ready", 32'(req1_ready), 32'd1);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
